sha256_mem_responder: RTL
=========================

# sha256_mem_responder

Word-addressed memory responder serving the memory port driven by the `sha256` core: message reads, digest writes. It also exposes a host-side load/dump port. A testbench or SoC host uses that port to preload message words before `start` and to stream the digest back out after `done`. It sits beside the core in the system top and is the far end of the core's `mem_*` interface.

## Interface
Parameters:
- `DEPTH`, 16384: number of 32-bit words. Addresses `>= DEPTH` are out of range.
- `OOR_DATA`, 32'h0000_0000: read data returned for out-of-range addresses.

Ports:
- `clk`, in, 1: clock. Connected to the core's `mem_clk`.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `mem_we`, in, 1: core write enable.
- `mem_addr`, in, 16: core word address.
- `mem_write_data`, in, 32: core write data.
- `mem_read_data`, out, 32: core read data, registered.
- `load_valid`, in, 1: host write request.
- `load_ready`, out, 1: host write accepted when high together with `load_valid`.
- `load_addr`, in, 16: host write address.
- `load_data`, in, 32: host write data.
- `dump_start`, in, 1: pulse that begins a dump.
- `dump_addr`, in, 16: first word address of the dump.
- `dump_len`, in, 16: number of words to dump.
- `dump_valid`, out, 1: dump word available.
- `dump_ready`, in, 1: host accepts the dump word.
- `dump_data`, out, 32: current dump word.
- `dump_done`, out, 1: one-cycle pulse when the dump completes.
- `err`, out, 1: sticky out-of-range flag.
- `core_wr_count`, out, 16: count of core writes, saturating.

## Operation
- Two-port array. Port A belongs to the core. Port B is shared by host load (write) and dump (read).
- Core read: every cycle with `mem_we=0`, `mem_read_data` at edge k+1 equals `mem[mem_addr]` as sampled at edge k.
- Core write: every cycle with `mem_we=1`, the array is updated at the edge. `mem_read_data` holds its previous value.
- Host load: a handshake (`load_valid && load_ready`) writes `load_data` at the same edge. `load_ready = (state==IDLE)`.
- Same-address write on both ports in the same cycle: the core write wins and the host write is discarded. The handshake still completes.
- A port-A read of an address being written by port B in the same cycle returns the old data (read-before-write).
- Out-of-range access on any port:
  - reads return `OOR_DATA`;
  - writes are dropped;
  - `err` is set to 1 and stays set until reset.
- Dump address for word i is `(dump_addr + i) mod 2^16`. Out-of-range words follow the rule above.
- `core_wr_count` increments once per core write and holds at 16'hFFFF.

Dump FSM:
- IDLE:
  - `dump_start` with `dump_len==0`: pulse `dump_done`, stay in IDLE.
  - `dump_start` with `dump_len!=0`: latch address and length, clear index, go to READ.
- READ: issue the port-B read, go to VALID.
- VALID:
  - `dump_valid=1`, and `dump_data` is held stable while `dump_ready=0`.
  - On `dump_ready`: increment the index. If it was the last word, pulse `dump_done` and go to IDLE; otherwise go to READ.
- `dump_start` outside IDLE is ignored.
- A load handshake and `dump_start` in the same IDLE cycle are both honoured. The dump read observes the loaded word.

## Timing
- Reset values:
  - `mem_read_data`=0, `dump_data`=0.
  - `dump_valid`=0, `dump_done`=0, `err`=0, `core_wr_count`=0.
  - `load_ready`=1 (FSM in IDLE).
- The array contents are not reset.
- Core read latency: 1 cycle.
- Dump timing:
  - The first `dump_valid` rises 2 cycles after `dump_start`.
  - Sustained throughput is 1 word per 2 cycles when `dump_ready` is tied high.
  - `dump_done` coincides with the cycle after the last accepted word.
- Reset asserted mid-dump aborts immediately. `dump_valid` and `dump_done` go low, FSM returns to IDLE, and no partial-dump state survives.
- Loads are refused (`load_ready=0`) for the entire dump, from READ through the final VALID.

## Structure
- Package `sha256_mem_pkg` contains:
  - the dump-state enum `{IDLE, READ, VALID}`;
  - the `DEPTH` default;
  - the `OOR_DATA` default;
  - the address width constant (16).
- One sub-module, `sha256_mem_dpram`: a pure dual-port RAM.
  - Each port has registered read data and write-first disabled (read-before-write).
  - Range checking, arbitration, FSM and counters live in the top.

## Test plan
- Core write then read: write 32'hCAFEF00D to addr 5, then `mem_addr=5, mem_we=0` → `mem_read_data=32'hCAFEF00D` exactly 1 cycle later; `core_wr_count=1`.
- Load 4 words (32'h61626380, 0, 0, 32'h18) at 0..3, then dump `addr=0, len=4` with `dump_ready=1` → same 4 words in order, first `dump_valid` 2 cycles after start, one `dump_done` pulse.
- Backpressure: dump `len=2` with `dump_ready` low for 5 cycles → `dump_data` stable, `load_ready=0` throughout; both words delivered once ready is released.
- Collision: core writes 32'h1 and host loads 32'h2 to addr 7 in the same cycle → `mem[7]=32'h1`, and the load handshake completes.
- Out-of-range: with `DEPTH=16`, core read of addr 20 returns 0 and `err` rises; dump `addr=16'hFFFF, len=2` yields words `OOR_DATA`, then `mem[0]`.
- Reset mid-dump with `len=8`, then `dump_len=0` start → outputs at reset values after reset; the zero-length start gives an immediate `dump_done` with no `dump_valid`.

Source files
------------

// File: rtl/sha256_mem_pkg.sv
// Shared types and defaults for the sha256 memory responder.
package sha256_mem_pkg;

  // Word address width of both the core port and the host port.
  localparam int ADDR_W = 16;

  // Default array depth in 32-bit words.
  localparam int DEFAULT_DEPTH = 16384;

  // Default read data for addresses at or above DEPTH.
  localparam logic [31:0] DEFAULT_OOR_DATA = 32'h0000_0000;

  // Dump engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } dump_state_t;

endpackage

// File: rtl/sha256_mem_dpram.sv
// Plain dual-port RAM: one write and one registered read per port,
// read-before-write on every port combination.
module sha256_mem_dpram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Array writes from both ports; the caller never presents two writes to one address.
  // NOTE: the storage array is deliberately left without a reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Port A read register, updated only when a read is requested.
  // NOTE: non-blocking assignment here is what yields the old word on a same-edge write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  a_rdata <= '0;
    else if (a_re) a_rdata <= mem[a_addr];
  end

  // Port B read register, updated only when a read is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  b_rdata <= '0;
    else if (b_re) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory responder for the sha256 core: core port A, host load/dump on port B,
// range checking, write arbitration, dump engine and write counter.
module sha256_mem_responder
  import sha256_mem_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] OOR_DATA = DEFAULT_OOR_DATA
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_write_data,
  output logic [31:0]       mem_read_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W-1:0] dump_len,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              dump_done,
  output logic              err,
  output logic [15:0]       core_wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  dump_state_t       state, state_next;
  logic [ADDR_W-1:0] base_addr, len_q, idx;
  logic              done_next, latch_dump, advance;
  logic              a_oor_q, b_oor_q;
  logic [31:0]       a_rdata, b_rdata;

  logic              load_fire, dump_rd, a_in, b_in, core_wr, collide;
  logic              a_we, a_re, b_we, b_re;
  logic [ADDR_W-1:0] b_addr;

  // Port B is either the host load address (IDLE) or the current dump word address.
  assign load_fire = load_valid && load_ready;
  assign dump_rd   = (state == READ);
  assign b_addr    = dump_rd ? base_addr + idx : load_addr;
  assign a_in      = in_range(mem_addr);
  assign b_in      = in_range(b_addr);
  assign core_wr   = mem_we && a_in;
  assign collide   = core_wr && (mem_addr == load_addr);
  assign a_we      = core_wr;
  assign a_re      = !mem_we && a_in;
  assign b_we      = load_fire && b_in && !collide;
  assign b_re      = dump_rd && b_in;

  sha256_mem_dpram #(.DEPTH(DEPTH), .AW(AW), .DW(32)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_we    (a_we),
    .a_re    (a_re),
    .a_addr  (mem_addr[AW-1:0]),
    .a_wdata (mem_write_data),
    .a_rdata (a_rdata),
    .b_we    (b_we),
    .b_re    (b_re),
    .b_addr  (b_addr[AW-1:0]),
    .b_wdata (load_data),
    .b_rdata (b_rdata)
  );

  // Dump next-state logic and one-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    done_next  = 1'b0;
    latch_dump = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          if (dump_len == '0) begin
            done_next = 1'b1;
          end else begin
            latch_dump = 1'b1;
            state_next = READ;
          end
        end
      end
      READ: state_next = VALID;
      VALID: begin
        if (dump_ready) begin
          advance = 1'b1;
          if (idx + 16'd1 == len_q) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = READ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Dump state, parameters, word index and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      base_addr <= '0;
      len_q     <= '0;
      idx       <= '0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_next;
      dump_done <= done_next;
      if (latch_dump) begin
        base_addr <= dump_addr;
        len_q     <= dump_len;
        idx       <= '0;
      end else if (advance) begin
        idx <= idx + 16'd1;
      end
    end
  end

  // Out-of-range markers that follow each read register, so held data stays consistent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_oor_q <= 1'b0;
      b_oor_q <= 1'b0;
    end else begin
      if (!mem_we) a_oor_q <= !a_in;
      if (dump_rd) b_oor_q <= !b_in;
    end
  end

  // Sticky range error and saturating core write counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err           <= 1'b0;
      core_wr_count <= '0;
    end else begin
      if (!a_in || ((load_fire || dump_rd) && !b_in)) err <= 1'b1;
      if (mem_we && core_wr_count != 16'hFFFF) core_wr_count <= core_wr_count + 16'd1;
    end
  end

  assign mem_read_data = a_oor_q ? OOR_DATA : a_rdata;
  assign dump_data     = b_oor_q ? OOR_DATA : b_rdata;
  assign dump_valid    = (state == VALID);
  assign load_ready    = (state == IDLE);

endmodule
